seq_divider: RTL and testbench

Sequential restoring divider: the inverse of the team's 4x4 combinational multiplier. It divides an 8-bit dividend by a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder. It resolves one quotient bit per clock behind a Start/Done handshake. Feeding it a `multiplicator` product and either original operand must return the other operand with remainder 0.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 118 +++++++++++
 tb/tb_seq_divider.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned DIV_VW = 4;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_DW-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned VW = DIV_VW
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  logic [VW:0] r_shift;
  logic        unused_r_msb;

  // R always stays below D between steps, so its top bit is shifted out unused.
  assign unused_r_msb = r_i[VW];

  always_comb begin
    r_shift = {r_i[VW-1:0], q_msb_i};
    q_bit_o = (r_shift >= {1'b0, d_i});
    r_o     = q_bit_o ? (r_shift - {1'b0, d_i}) : r_shift;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [DW-1:0] din0,
  input  logic [VW-1:0] din1,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem,
  output logic          Busy,
  output logic          Done,
  output logic          DivZero
);

  localparam int unsigned CNT_W = $clog2(DW) + 1;

  div_state_t       state_q;
  logic [DW-1:0]    q_q;
  logic [VW-1:0]    d_q;
  logic [VW:0]      r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    quo_q;
  logic [VW-1:0]    rem_q;
  logic             busy_q;
  logic             done_q;
  logic             divzero_q;

  logic [VW:0]      r_d;
  logic [DW-1:0]    q_d;
  logic             q_bit;

  div_step #(
    .VW(VW)
  ) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (r_d),
    .q_bit_o (q_bit)
  );

  assign q_d = {q_q[DW-2:0], q_bit};

  // Control FSM plus datapath registers; result registers only load on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      d_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            q_q    <= din0;
            d_q    <= din1;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (din1 == '0) begin
              state_q   <= DONE;
              quo_q     <= {DW{DIV_ZERO_QUO[0]}};
              rem_q     <= '0;
              divzero_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DW - 1)) begin
            state_q   <= DONE;
            quo_q     <= q_d;
            rem_q     <= r_d[VW-1:0];
            divzero_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quo     = quo_q;
  assign rem     = rem_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results popped on each Done.
module tb_seq_divider;

  typedef struct {
    int unsigned quo;
    int unsigned rem;
    int unsigned dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [7:0] din0;
  logic [3:0] din1;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (Start),
    .din0    (din0),
    .din1    (din1),
    .quo     (quo),
    .rem     (rem),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer division, all-ones quotient on a zero divisor.
  task automatic push_exp(input int unsigned a, input int unsigned b);
    exp_t e;
    if (b == 0) begin
      e.quo = 255; e.rem = 0; e.dz = 1;
    end else begin
      e.quo = a / b; e.rem = a % b; e.dz = 0;
    end
    sb.push_back(e);
  endtask

  // Steps negedges after an accepting edge until Done; optionally keeps Start high and scrambles operands.
  task automatic wait_done(input bit hold, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (Busy) bcnt++;
      if (Done || lat >= 40) break;
      if (hold) begin
        din0 = 8'($urandom);
        din1 = 4'($urandom_range(1, 15));
      end else begin
        Start = 1'b0;
      end
    end
    check("done_seen", 32'(Done), 1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_quo"}, 32'(quo), e.quo);
      check({tag, "_rem"}, 32'(rem), e.rem);
      check({tag, "_dz"},  32'(DivZero), e.dz);
    end
  endtask

  // Full single-pulse division with latency and Done-width checks.
  task automatic do_div(input int unsigned a, input int unsigned b, input string tag);
    int lat, bcnt;
    @(negedge clk);
    Start = 1'b1;
    din0  = 8'(a);
    din1  = 4'(b);
    push_exp(a, b);
    @(posedge clk);
    wait_done(1'b0, lat, bcnt);
    Start = 1'b0;
    compare_result(tag);
    check({tag, "_lat"}, 32'(lat), (b == 0) ? 1 : 9);
    check({tag, "_busy_cycles"}, 32'(bcnt), (b == 0) ? 1 : 9);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(Done), 0);
    check({tag, "_busy_fall"}, 32'(Busy), 0);
  endtask

  initial begin
    int lat, bcnt, done_hits;
    rst   = 1'b1;
    Start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_quo", 32'(quo), 0);
    check("rst_rem", 32'(rem), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_dz", 32'(DivZero), 0);
    rst = 1'b0;

    do_div(200, 7, "d200_7");
    do_div(255, 1, "d255_1");
    do_div(15, 15, "d15_15");
    do_div(3, 9, "d3_9");
    do_div(0, 5, "d0_5");
    do_div(100, 0, "d100_0");
    do_div(225, 15, "d225_15");

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        do_div(32'(a * b), 32'(b), "inverse");

    for (int i = 0; i < 40; i++)
      do_div($urandom_range(0, 255), $urandom_range(0, 15), "random");

    // Start held high: scrambled operands during CALC must not leak, next accept exactly DW+2 edges later.
    @(negedge clk);
    Start = 1'b1;
    din0  = 8'd200;
    din1  = 4'd7;
    push_exp(200, 7);
    @(posedge clk);
    wait_done(1'b1, lat, bcnt);
    compare_result("hold_first");
    din0 = 8'd99;
    din1 = 4'd9;
    push_exp(99, 9);
    @(negedge clk);
    check("hold_idle_gap", 32'(Busy), 0);
    @(negedge clk);
    check("hold_reaccept", 32'(Busy), 1);
    Start = 1'b0;
    wait_done(1'b0, lat, bcnt);
    compare_result("hold_second");
    check("hold_second_lat", 32'(lat), 8);
    @(negedge clk);

    // Reset during CALC step 4 of 200/7: outputs cleared, no Done for the aborted run.
    @(negedge clk);
    Start = 1'b1;
    din0  = 8'd200;
    din1  = 4'd7;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_quo", 32'(quo), 0);
    check("abort_rem", 32'(rem), 0);
    check("abort_busy", 32'(Busy), 0);
    check("abort_done", 32'(Done), 0);
    check("abort_dz", 32'(DivZero), 0);
    done_hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (Done) done_hits++;
    end
    check("abort_no_done", 32'(done_hits), 0);
    do_div(49, 7, "d49_7");

    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
